ram_dumper: RTL and testbench
=============================

Name: ram_dumper

Overview:
- Read-back counterpart of the UART bootloader. It streams a window of RAM out through the UART transmitter as a framed packet, so the host can verify a loaded image or capture results after a run.
- Frame format: 2-byte length header (MSB first), payload bytes, then a 1-byte two's-complement checksum.
- Sits beside the bootloader. The top level muxes ram_addr onto the RAM address while dumping=1, and muxes tx_data/transmit onto the UART the same way the bootloader's boot_tx_data/boot_transmit are muxed.

Parameters:
- ADDR_WIDTH, 16, width of RAM address, start_addr and length.
- RD_LAT, 1, cycles from ram_addr change to ram_data valid (≥1).

Ports:
- clk  input  1  system clock (CLOCK_50 domain, same as the uart).
- rst  input  1  asynchronous, active-high reset.
- trigger  input  1  level request; a rising edge is detected internally.
- start_addr  input  ADDR_WIDTH  first RAM address to dump; sampled on the trigger edge.
- length  input  ADDR_WIDTH  number of payload bytes; sampled on the trigger edge.
- ram_addr  output  ADDR_WIDTH  RAM read address.
- ram_data  input  8  RAM read data.
- tx_data  output  8  byte presented to the uart.
- transmit  output  1  one-cycle write strobe to the uart (tx_wr).
- tx_done  input  1  one-cycle pulse from the uart when the byte has been sent.
- dumping  output  1  high from the trigger edge until the end of the DONE state; owns RAM and UART while high.
- done  output  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset (async): state=IDLE; ram_addr=0, tx_data=0, transmit=0, dumping=0, done=0; checksum=0; counters=0; trigger edge register=0.
- Edge detect: trig_q<=trigger; edge = trigger & ~trig_q.
- An edge in any state other than IDLE is ignored; no re-arm.
- IDLE: on edge, latch start_addr→addr_r and length→remaining, clear checksum, set dumping=1 in the same edge, go to HDR_HI.
- HDR_HI: tx_data=remaining[15:8], transmit=1 for one cycle, go to WAIT_TX (next state HDR_LO).
- HDR_LO: same with remaining[7:0]. Next state is FETCH if remaining≠0, else CSUM.
- The header bytes are not included in the checksum.
- FETCH: ram_addr=addr_r; count RD_LAT cycles, then go to LOAD.
- LOAD: latch ram_data→tx_data; checksum<=checksum+ram_data (mod 256); go to SEND.
- SEND: transmit=1 for exactly one cycle; go to WAIT_TX (next state decided by remaining).
- WAIT_TX: hold tx_data; wait for tx_done.
  - After a payload byte: addr_r<=addr_r+1, wrapping 0xFFFF→0x0000; remaining<=remaining-1. If the new remaining≠0 go to FETCH, else CSUM.
  - After a header byte: go to the recorded next state.
  - After the checksum byte: go to DONE.
- CSUM: tx_data=(~checksum)+1, so payload sum + checksum ≡ 0 mod 256; transmit=1 for one cycle; go to WAIT_TX.
- DONE: done=1 for one cycle, dumping=0 on the next cycle, return to IDLE.
- tx_done pulses outside WAIT_TX are ignored.
- tx_done in the same cycle as transmit is not accepted; the earliest acceptance is the cycle after the strobe.
- transmit is never asserted twice without an intervening accepted tx_done.
- ram_addr holds its last value outside FETCH.
- length=0: frame is 0x00 0x00 0x00 (header plus checksum of an empty payload). RAM is never read.
- length=0xFFFF: 65535 payload bytes. 16-bit counters must not overflow.
- Reset mid-frame: immediate abort, outputs return to reset values, no done pulse. The host detects the short frame by timeout.
- Per-byte latency from tx_done to the next transmit strobe: RD_LAT+2 cycles for payload bytes, 1 cycle for the header→header and →CSUM transitions.

Test Plan:
- Reset, then trigger with start=0x0010, length=3, RAM[0x10..0x12]=0x01,0x02,0x03 → transmitted bytes 0x00,0x03,0x01,0x02,0x03,0xFA. One done pulse. dumping high throughout and low after.
- length=0 → exactly 0x00,0x00,0x00 transmitted. ram_addr never enters FETCH. done pulses once.
- start=0xFFFE, length=4, RAM[FFFE]=0x10, [FFFF]=0x20, [0000]=0x30, [0001]=0x40 → ram_addr sequence FFFE, FFFF, 0000, 0001. Checksum 0x60.
- A second trigger edge mid-frame, plus tx_done pulses injected during FETCH → frame unchanged and no extra transmit strobes. Delayed tx_done of 1000 cycles → transmit stays low and tx_data stays stable until it arrives.
- Assert rst during the 2nd payload byte → transmit=0, dumping=0, state IDLE immediately, no done pulse. A new trigger then produces a complete correct frame.
- RD_LAT=3 build with length=2 → each payload tx_data equals the RAM word at the current ram_addr, with 5 cycles from tx_done to the next strobe.

Source files
------------

// File: rtl/ram_dumper.sv
// ram_dumper: streams a RAM window out through the UART as a framed packet
// (2-byte big-endian length, payload bytes, two's-complement checksum byte).
module ram_dumper #(
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [7:0]            ram_data,
  output logic [7:0]            tx_data,
  output logic                  transmit,
  input  logic                  tx_done,
  output logic                  dumping,
  output logic                  done
);
  localparam int CW = $clog2(RD_LAT + 1);
  typedef enum logic [3:0] {IDLE, HDR_HI, HDR_LO, FETCH, LOAD, SEND, WAIT_TX, CSUM, DONE} state_t;
  state_t state_q, state_d, nxt_q, nxt_d;
  logic trig_q, trig_edge;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, rem_q, rem_d, ram_addr_q, ram_addr_d;
  logic [7:0] sum_q, sum_d, tx_data_q, tx_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic transmit_q, transmit_d, dumping_q, dumping_d, done_q, done_d;
  logic [15:0] hdr;
  logic fetch_last;
  assign trig_edge = trigger & ~trig_q;
  assign fetch_last = cnt_q == CW'(RD_LAT - 1);
  always_comb begin
    state_d = state_q;
    nxt_d = nxt_q;
    addr_d = addr_q;
    rem_d = rem_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: if (trig_edge) begin
        addr_d = start_addr;
        rem_d = length;
        sum_d = '0;
        state_d = HDR_HI;
      end
      HDR_HI: begin
        nxt_d = HDR_LO;
        state_d = WAIT_TX;
      end
      HDR_LO: begin
        nxt_d = (rem_q != '0) ? FETCH : CSUM;
        state_d = WAIT_TX;
      end
      FETCH: begin
        cnt_d = fetch_last ? '0 : cnt_q + 1'b1;
        state_d = fetch_last ? LOAD : FETCH;
      end
      LOAD: begin
        tx_data_d = ram_data;
        sum_d = sum_q + ram_data;
        state_d = SEND;
      end
      SEND: begin
        // SEND as the return marker means "a payload byte is in flight"
        nxt_d = SEND;
        state_d = WAIT_TX;
      end
      WAIT_TX: if (tx_done) begin
        if (nxt_q == SEND) begin
          addr_d = addr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          state_d = (rem_d != '0) ? FETCH : CSUM;
        end else begin
          state_d = nxt_q;
        end
      end
      CSUM: begin
        nxt_d = DONE;
        state_d = WAIT_TX;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    hdr = 16'(rem_d);
    tx_data_d = (state_d == HDR_HI) ? hdr[15:8] :
                (state_d == HDR_LO) ? hdr[7:0] :
                (state_d == CSUM)   ? ~sum_q + 8'd1 : tx_data_d;
  end
  // Outputs are registered from the next state so they line up with the state they belong to
  assign ram_addr_d = (state_d == FETCH) ? addr_d : ram_addr_q;
  assign transmit_d = state_d inside {HDR_HI, HDR_LO, SEND, CSUM};
  assign dumping_d = state_d != IDLE;
  assign done_d = state_d == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      nxt_q <= IDLE;
      trig_q <= 1'b0;
      addr_q <= '0;
      rem_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      ram_addr_q <= '0;
      tx_data_q <= '0;
      transmit_q <= 1'b0;
      dumping_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nxt_q <= nxt_d;
      trig_q <= trigger;
      addr_q <= addr_d;
      rem_q <= rem_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      ram_addr_q <= ram_addr_d;
      tx_data_q <= tx_data_d;
      transmit_q <= transmit_d;
      dumping_q <= dumping_d;
      done_q <= done_d;
    end
  end
  assign ram_addr = ram_addr_q;
  assign tx_data = tx_data_q;
  assign transmit = transmit_q;
  assign dumping = dumping_q;
  assign done = done_q;
endmodule

// File: tb/tb_ram_dumper.sv
// tb_ram_dumper: scoreboard bench for ram_dumper covering framing, empty and wrapping
// windows, spurious tx_done/trigger, slow UART, reset abort and an RD_LAT=3 instance.
module tb_ram_dumper;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, trig, transmit, tx_done_r, inj, tx_done, dumping, done;
  logic [15:0] start, len, ram_addr;
  logic [7:0] ram_data, tx_data;
  logic trig3, transmit3, tx_done3, dumping3, done3;
  logic [15:0] start3, len3, ram_addr3;
  logic [7:0] ram_data3, tx3, p1, p2;
  logic [7:0] mem [0:65535];
  assign tx_done = tx_done_r | inj;

  ram_dumper #(.ADDR_WIDTH(16), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .trigger(trig), .start_addr(start), .length(len),
    .ram_addr(ram_addr), .ram_data(ram_data), .tx_data(tx_data), .transmit(transmit),
    .tx_done(tx_done), .dumping(dumping), .done(done));
  ram_dumper #(.ADDR_WIDTH(16), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .trigger(trig3), .start_addr(start3), .length(len3),
    .ram_addr(ram_addr3), .ram_data(ram_data3), .tx_data(tx3), .transmit(transmit3),
    .tx_done(tx_done3), .dumping(dumping3), .done(done3));

  always @(posedge clk) ram_data <= mem[ram_addr];
  always @(posedge clk) begin
    p1 <= mem[ram_addr3];
    p2 <= p1;
    ram_data3 <= p2;
  end

  int checks = 0, passes = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  logic [7:0] exp_q [$];
  logic [15:0] addr_log [$];
  int strobes = 0, done_cnt = 0;
  logic outstanding = 1'b0;
  logic [7:0] held = 8'h00;
  logic [15:0] last_addr = 16'h0000;

  // Monitor: pops the scoreboard on every strobe and checks UART handshake rules
  initial forever begin
    @(negedge clk);
    if (rst) begin
      outstanding = 1'b0;
    end else begin
      if (transmit) begin
        strobes++;
        chk("no_double_strobe", outstanding, 0);
        chk("dumping_on_strobe", dumping, 1);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL tx_byte: got 0x%0h expected none (queue empty)", tx_data);
        end else chk("tx_byte", tx_data, exp_q.pop_front());
        outstanding = 1'b1;
        held = tx_data;
      end
      if (tx_done_r && outstanding) begin
        chk("tx_data_stable", tx_data, held);
        outstanding = 1'b0;
      end
      if (done) begin
        done_cnt++;
        chk("dumping_during_done", dumping, 1);
      end
      if (ram_addr != last_addr) begin
        addr_log.push_back(ram_addr);
        last_addr = ram_addr;
      end
    end
  end

  int tx_delay = 1, resp_k = 0, inj_len = 0;
  bit inject_en = 1'b0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // UART model: answers each strobe with tx_done after tx_delay cycles, optionally
  // adding spurious tx_done during the strobe cycle and during FETCH/LOAD
  initial begin
    int k;
    tx_done_r = 1'b0;
    inj = 1'b0;
    tick();
    forever begin
      if (transmit && !rst) begin
        k = resp_k;
        resp_k++;
        inj = inject_en;
        tick();
        inj = 1'b0;
        repeat (tx_delay - 1) tick();
        tx_done_r = 1'b1;
        tick();
        tx_done_r = 1'b0;
        if (inject_en && k >= 1 && k <= inj_len) begin
          inj = 1'b1;
          tick();
          tick();
          inj = 1'b0;
        end
      end else tick();
    end
  end

  task automatic run_frame(input logic [15:0] s, input logic [15:0] l, input int limit, input bit retrig);
    int n = 0;
    int d0 = done_cnt;
    resp_k = 0;
    inj_len = int'(l);
    addr_log.delete();
    start = s;
    len = l;
    trig = 1'b1;
    @(negedge clk);
    chk("dumping_after_trigger", dumping, 1);
    trig = 1'b0;
    while (done_cnt == d0 && n < limit) begin
      @(negedge clk);
      n++;
      if (retrig) trig = (n >= 20 && n < 30);
    end
    chk("done_pulse", done_cnt - d0, 1);
    @(negedge clk);
    chk("dumping_low_after", dumping, 0);
    chk("bytes_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("single_done", done_cnt - d0, 1);
  endtask

  logic [15:0] wa [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [7:0] e3 [5] = '{8'h00, 8'h02, 8'h5A, 8'hA5, 8'h01};
  int lat3 [5] = '{0, 1, 5, 5, 1};

  initial begin
    int n, d0;
    rst = 1'b1;
    trig = 1'b0;
    start = '0;
    len = '0;
    trig3 = 1'b0;
    start3 = '0;
    len3 = '0;
    tx_done3 = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h01; mem[16'h0011] = 8'h02; mem[16'h0012] = 8'h03;
    mem[16'hFFFE] = 8'h10; mem[16'hFFFF] = 8'h20; mem[16'h0000] = 8'h30; mem[16'h0001] = 8'h40;
    mem[16'h0020] = 8'h80; mem[16'h0021] = 8'h81;
    mem[16'h0030] = 8'h5A; mem[16'h0031] = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_ram_addr", ram_addr, 16'h0000);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_transmit", transmit, 0);
    chk("rst_dumping", dumping, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    exp_q = {8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
    run_frame(16'h0010, 16'd3, 300, 1'b0);
    chk("basic_addr_count", addr_log.size(), 3);

    exp_q = {8'h00, 8'h00, 8'h00};
    run_frame(16'h1234, 16'd0, 300, 1'b0);
    chk("empty_no_fetch", addr_log.size(), 0);

    exp_q = {8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h60};
    run_frame(16'hFFFE, 16'd4, 300, 1'b0);
    chk("wrap_addr_count", addr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("wrap_addr", (i < addr_log.size()) ? addr_log[i] : 16'hxxxx, wa[i]);

    inject_en = 1'b1;
    tx_delay = 1000;
    exp_q = {8'h00, 8'h02, 8'h80, 8'h81, 8'hFF};
    run_frame(16'h0020, 16'd2, 8000, 1'b1);
    inject_en = 1'b0;
    tx_delay = 1;

    exp_q = {8'h00, 8'h03, 8'h01, 8'h02};
    d0 = done_cnt;
    n = strobes;
    resp_k = 0;
    inj_len = 3;
    start = 16'h0010;
    len = 16'd3;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    for (int i = 0; i < 200 && strobes < n + 4; i++) @(negedge clk);
    chk("abort_reached_payload2", strobes - n, 4);
    rst = 1'b1;
    #1;
    chk("abort_transmit", transmit, 0);
    chk("abort_dumping", dumping, 0);
    chk("abort_ram_addr", ram_addr, 16'h0000);
    chk("abort_tx_data", tx_data, 8'h00);
    chk("abort_bytes_sent", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    exp_q = {8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
    run_frame(16'h0010, 16'd3, 300, 1'b0);

    start3 = 16'h0030;
    len3 = 16'd2;
    trig3 = 1'b1;
    for (int b = 0; b < 5; b++) begin
      n = 0;
      while (!transmit3 && n < 50) begin
        @(negedge clk);
        n++;
      end
      trig3 = 1'b0;
      if (b > 0) chk("rdlat3_latency", n + 1, lat3[b]);
      chk("rdlat3_byte", tx3, e3[b]);
      if (b == 2 || b == 3) chk("rdlat3_addr", ram_addr3, 16'h0030 + 16'(b - 2));
      @(negedge clk);
      tx_done3 = 1'b1;
      @(negedge clk);
      tx_done3 = 1'b0;
    end
    chk("rdlat3_done", done3, 1);
    @(negedge clk);
    chk("rdlat3_dumping_low", dumping3, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
